// File: rtl/counter_sequencer_pkg.sv
// Shared types and default widths for the counter sequencer.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cseq_state_t;

    localparam int CSEQ_N_DEF = 8;
    localparam int CSEQ_P_DEF = 8;

endpackage

// File: rtl/counter_sequencer_tick_divider.sv
// Reloadable P-bit down-counter; tick marks the terminal count of zero.
module tick_divider #(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         CLRb,
    input  logic         en,
    input  logic         reload,
    input  logic [P-1:0] load_val,
    output logic         tick
);

    logic [P-1:0] count;

    assign tick = (count == '0);

    always_ff @(posedge clk) begin
        if (!CLRb) begin
            count <= '0;
        end else if (reload || (en && tick)) begin
            count <= load_val;
        end else if (en) begin
            count <= count - P'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command side of the shared up/down counter: load, prescaled stepping, done.
// Optional macro COUNT_SEQ_REPEAT_EN adds repeat_en to loop DONE back to LOAD.
//
// state | meaning
// IDLE  | no command, waits for start
// LOAD  | counter load of latched start value
// RUN   | prescaled stepping toward stop value
// DONE  | one-cycle completion pulse
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int N = CSEQ_N_DEF,
    parameter int P = CSEQ_P_DEF
) (
    input  logic         clk,
    input  logic         CLRb,
    input  logic         start,
    input  logic [N-1:0] start_val,
    input  logic [N-1:0] stop_val,
    input  logic         down_in,
    input  logic [P-1:0] prescale,
    input  logic         abort,
`ifdef COUNT_SEQ_REPEAT_EN
    input  logic         repeat_en,
`endif
    output logic         busy,
    output logic         done,
    output logic         cnt_E,
    output logic         cnt_LD,
    output logic         cnt_DOWN,
    output logic [N-1:0] cnt_D,
    output logic [N-1:0] shadow
);

    cseq_state_t  state, state_nxt;
    logic [N-1:0] start_q, stop_q, step_val;
    logic [P-1:0] pre_q;
    logic         dir_q;
    logic         latch_en, load_en, step_en, tick;

    tick_divider #(.P(P)) u_div (
        .clk      (clk),
        .CLRb     (CLRb),
        .en       (state == RUN),
        .reload   (load_en),
        .load_val (pre_q),
        .tick     (tick)
    );

    assign step_val = dir_q ? (shadow - N'(1)) : (shadow + N'(1));

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        load_en   = 1'b0;
        step_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    latch_en  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    load_en   = 1'b1;
                    state_nxt = (start_q == stop_q) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    step_en = 1'b1;
                    if (step_val == stop_q) state_nxt = DONE;
                end
            end
            DONE: begin
`ifdef COUNT_SEQ_REPEAT_EN
                state_nxt = repeat_en ? LOAD : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // abort gates the enable in the same cycle so a pending load or step never reaches the counter
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign cnt_E    = load_en | step_en;
    assign cnt_LD   = (state == LOAD);
    assign cnt_DOWN = step_en & dir_q;
    assign cnt_D    = start_q;

    always_ff @(posedge clk) begin
        if (!CLRb) begin
            state   <= IDLE;
            start_q <= '0;
            stop_q  <= '0;
            pre_q   <= '0;
            dir_q   <= 1'b0;
            shadow  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                start_q <= start_val;
                stop_q  <= stop_val;
                pre_q   <= prescale;
                dir_q   <= down_in;
            end
            if (load_en) begin
                shadow <= start_q;
            end else if (step_en) begin
                shadow <= step_val;
            end
        end
    end

endmodule
